multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Multi-cycle main control FSM for the RV32 core; successor to the single-cycle opcode decoder.
// - Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a ready handshake.
// - Drives all datapath enables and muxes, and traps on illegal opcodes and memory timeouts.
// - Sits between the instruction register and the datapath; the datapath owns PC, IR, regfile and ALU.
// PARAMETERS
// - MEM_TIMEOUT  16  max wait cycles for mem_ready_i; 0 = timeout disabled
// - CNT_W        $clog2(MEM_TIMEOUT+1)  wait-counter width (derived; do not override)
// PORTS
// - clk_i           in   1   single clock; all state on rising edge
// - rst_ni          in   1   reset, asynchronous, active-low
// - opcode_i        in   7   IR[6:0]
// - funct7_i        in   7   IR[31:25]
// - mem_ready_i     in   1   memory completes current request this cycle
// - branch_taken_i  in   1   ALU comparison result for the current branch
// - muldiv_done_i   in   1   mul/div unit result valid (used only with CTRL_MULDIV_EN)
// - mem_req_o       out  1   memory request
// - mem_we_o        out  1   store request (only ever high with mem_req_o)
// - mem_src_o       out  1   address select: 0 = PC, 1 = ALU result
// - ir_we_o         out  1   load IR from memory read data
// - pc_we_o         out  1   PC update strobe
// - pc_src_o        out  2   next PC: 00 = pc+4, 01 = pc+imm, 10 = jalr target, 11 = trap vector
// - alu_op_o        out  2   00 = add, 01 = branch compare, 10 = R-type, 11 = I-type
// - alu_src_a_o     out  2   00 = rs1, 01 = PC, 10 = zero
// - alu_src_b_o     out  1   0 = rs2, 1 = immediate
// - reg_we_o        out  1   register-file write enable
// - wb_sel_o        out  2   write-back source: 00 = ALU, 01 = memory, 10 = pc+4, 11 = mul/div
// - muldiv_start_o  out  1   one-cycle start pulse to the mul/div unit
// - trap_o          out  1   trap taken (one-cycle pulse)
// - trap_cause_o    out  2   01 = illegal opcode, 10 = memory timeout; held until the next trap
// - state_o         out  3   current state, for debug
// BEHAVIOUR
// - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULDIV=5, TRAP=6.
// - Reset (asynchronous, any time, including mid-request): state = FETCH, wait counter = 0, trap_cause_o = 0.
//   - All registered outputs go to 0; mem_req_o is 0 for the reset cycles only.
// - Control outputs are decoded combinationally from state and the latched opcode; unlisted outputs are 0.
// - FETCH:
//   - mem_req_o = 1, mem_src_o = 0.
//   - On mem_ready_i: ir_we_o = 1, go to DECODE.
//   - A request, once raised, is never dropped before ready or timeout. Same-cycle ready means zero wait.
// - DECODE: latch opcode_i and funct7_i. Any unknown opcode -> TRAP with cause 01.
// - EXEC, per opcode:
//   - R-type (0110011): alu_op = 10 -> WB.
//   - I-type (0010011): alu_op = 11, src_b = 1 -> WB.
//   - Load/store (0000011/0100011): alu_op = 00, src_b = 1 -> MEM.
//   - Branch (1100011): alu_op = 01, pc_we = 1, pc_src = branch_taken_i ? 01 : 00 -> FETCH.
//   - JAL/JALR -> WB.
//   - LUI: src_a = 10, src_b = 1 -> WB. AUIPC: src_a = 01, src_b = 1 -> WB.
// - MEM:
//   - mem_req_o = 1, mem_src_o = 1, mem_we_o = store.
//   - On ready: load -> WB; store -> FETCH with pc_we = 1, pc_src = 00.
// - WB:
//   - reg_we_o = 1, pc_we_o = 1.
//   - wb_sel: 01 for load, 10 for JAL/JALR, 11 after MULDIV, else 00.
//   - pc_src: 01 for JAL, 10 for JALR, else 00. Then -> FETCH.
// - Wait counter:
//   - Counts every FETCH/MEM cycle without mem_ready_i; clears on ready and on state exit.
//   - Reaching MEM_TIMEOUT -> TRAP with cause 10. Ready arriving on that same cycle wins (no trap).
// - TRAP: trap_o = 1, pc_we = 1, pc_src = 11, no reg/mem write; -> FETCH after one cycle.
// - Latency with zero-wait memory:
//   - ALU/LUI/AUIPC/JAL/JALR: 4 cycles. Load: 5. Store: 4. Branch: 3. Illegal: 3.
// - Exactly one pc_we_o pulse per retired or trapped instruction. Never reg_we_o and mem_we_o together.
// CONFIGURATION
// - CTRL_MULDIV_EN defined: opcode 0110011 with funct7 = 0000001 goes EXEC -> MULDIV.
//   - muldiv_start_o pulses on the first MULDIV cycle.
//   - Stays in MULDIV until muldiv_done_i -> WB with wb_sel = 11.
//   - muldiv_done_i on the start cycle is accepted. MEM_TIMEOUT does not apply to MULDIV.
// - CTRL_MULDIV_EN undefined: that encoding is illegal -> TRAP cause 01.
//   - muldiv_start_o is tied 0; muldiv_done_i is ignored; state 5 is unreachable.
// TESTING
// - Reset then ADD with ready tied 1 -> states 0,1,2,4 then 0; reg_we_o=1 and wb_sel_o=00 in cycle 4 only.
// - LW with ready low for 3 cycles in MEM -> mem_req_o held 4 cycles, then WB with wb_sel_o=01.
// - Branch with branch_taken_i=1 / 0 -> pc_we_o=1 in EXEC with pc_src_o=01 / 00; no reg_we_o.
// - FETCH with ready never asserted, MEM_TIMEOUT=16 -> trap_o on cycle 17, cause 10, pc_src_o=11.
//   - Repeat with ready on the 16th wait cycle -> no trap.
// - Opcode 1111111 -> TRAP cause 01 at cycle 3; rst_ni low mid-MEM -> state 0, mem_req_o=0 immediately.
// - CTRL_MULDIV_EN, MUL with done after 5 cycles -> one muldiv_start_o pulse, 5 MULDIV cycles, WB wb_sel_o=11.
//   - Without the macro -> trap cause 01.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multi-cycle RV32 core. Sequences FETCH, DECODE,
//   EXEC, MEM and WB over a shared memory port with a ready handshake. It
//   drives every datapath enable and mux select. It traps on illegal opcodes
//   and on memory requests that exceed MEM_TIMEOUT wait cycles
//   (MEM_TIMEOUT = 0 disables the timeout).
//
//   Optional feature: define CTRL_MULDIV_EN to route R-type with
//   funct7 = 0000001 through the MULDIV state. When it is undefined, that
//   encoding is illegal and muldiv_done_i is ignored.
//
//   Ports
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     opcode_i/funct7_i  instruction fields from the IR (latched in DECODE)
//     mem_ready_i        memory completes the current request this cycle
//     branch_taken_i     branch comparison result (used in EXEC)
//     muldiv_done_i      mul/div result valid
//     mem_req_o/we_o/src_o, ir_we_o, pc_we_o, pc_src_o, alu_op_o,
//     alu_src_a_o, alu_src_b_o, reg_we_o, wb_sel_o   datapath controls
//     muldiv_start_o     one-cycle start pulse to the mul/div unit
//     trap_o, trap_cause_o   trap pulse and sticky cause (01 illegal, 10 timeout)
//     state_o            current state for debug
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  input  logic       mem_ready_i,
  input  logic       branch_taken_i,
  input  logic       muldiv_done_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_src_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       reg_we_o,
  output logic [1:0] wb_sel_o,
  output logic       muldiv_start_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MULDIV = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef CTRL_MULDIV_EN
  localparam bit MULDIV_OK = 1'b1;
`else
  localparam bit MULDIV_OK = 1'b0;
`endif

  // A zero-width counter is not legal, so keep at least one bit.
  localparam int            CW       = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] TMO_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [6:0]    funct7_q, funct7_d;
  logic          md_busy_q, md_busy_d;

  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, trap_c, md_start_c;
  logic tmo_hit, is_mul_q;

  function automatic logic op_legal(input logic [6:0] op, input logic [6:0] f7);
    logic ok;
    case (op)
      OP_R:                              ok = MULDIV_OK || (f7 != F7_MULDIV);
      OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The request has waited MEM_TIMEOUT cycles once this cycle also goes
  // unanswered; a ready in the same cycle takes priority.
  assign tmo_hit  = (MEM_TIMEOUT != 0) && (cnt_q == TMO_LAST);
  assign is_mul_q = (opcode_q == OP_R) && (funct7_q == F7_MULDIV);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    cause_d     = cause_q;
    opcode_d    = opcode_q;
    funct7_d    = funct7_q;
    md_busy_d   = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    trap_c      = 1'b0;
    md_start_c  = 1'b0;
    mem_src_o   = 1'b0;
    pc_src_o    = 2'b00;
    alu_op_o    = 2'b00;
    alu_src_a_o = 2'b00;
    alu_src_b_o = 1'b0;
    wb_sel_o    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready_i) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          cnt_d = (MEM_TIMEOUT == 0) ? '0 : cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        opcode_d = opcode_i;
        funct7_d = funct7_i;
        if (op_legal(opcode_i, funct7_i)) begin
          state_d = S_EXEC;
        end else begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (opcode_q)
          OP_R: begin
            if (MULDIV_OK && is_mul_q) state_d  = S_MULDIV;
            else                       alu_op_o = 2'b10;
          end
          OP_I: begin
            alu_op_o    = 2'b11;
            alu_src_b_o = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_o = 1'b1;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_o = 2'b01;
            pc_we_c  = 1'b1;
            pc_src_o = branch_taken_i ? 2'b01 : 2'b00;
            state_d  = S_FETCH;
          end
          OP_LUI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 1'b1;
          end
          OP_AUIPC: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_src_o = 1'b1;
        mem_we_c  = (opcode_q == OP_STORE);
        if (mem_ready_i) begin
          if (opcode_q == OP_STORE) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          cnt_d = (MEM_TIMEOUT == 0) ? '0 : cnt_q + CW'(1);
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        state_d  = S_FETCH;
        if (opcode_q == OP_LOAD)                             wb_sel_o = 2'b01;
        else if (opcode_q == OP_JAL || opcode_q == OP_JALR) wb_sel_o = 2'b10;
        else if (MULDIV_OK && is_mul_q)                     wb_sel_o = 2'b11;
        if (opcode_q == OP_JAL)       pc_src_o = 2'b01;
        else if (opcode_q == OP_JALR) pc_src_o = 2'b10;
      end
      S_MULDIV: begin
`ifdef CTRL_MULDIV_EN
        // md_busy_q marks cycles after the first, so start fires once.
        md_start_c = !md_busy_q;
        if (muldiv_done_i) state_d   = S_WB;
        else               md_busy_d = 1'b1;
`else
        state_d = S_FETCH;
`endif
      end
      S_TRAP: begin
        trap_c   = 1'b1;
        pc_we_c  = 1'b1;
        pc_src_o = 2'b11;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      cause_q   <= 2'b00;
      opcode_q  <= 7'd0;
      funct7_q  <= 7'd0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      opcode_q  <= opcode_d;
      funct7_q  <= funct7_d;
      md_busy_q <= md_busy_d;
    end
  end

`ifndef CTRL_MULDIV_EN
  logic unused_md;
  assign unused_md = muldiv_done_i | md_busy_q;
`endif

  // Strobes are masked while reset is held so no request or write escapes
  // during the reset cycles (state is FETCH, which would otherwise request).
  assign mem_req_o      = mem_req_c  & rst_ni;
  assign mem_we_o       = mem_we_c   & rst_ni;
  assign ir_we_o        = ir_we_c    & rst_ni;
  assign pc_we_o        = pc_we_c    & rst_ni;
  assign reg_we_o       = reg_we_c   & rst_ni;
  assign trap_o         = trap_c     & rst_ni;
  assign muldiv_start_o = md_start_c & rst_ni;
  assign trap_cause_o   = cause_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  localparam int TMO = 16;
`ifdef CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [6:0] opcode_i, funct7_i;
  logic       mem_ready_i, branch_taken_i, muldiv_done_i;
  logic       mem_req_o, mem_we_o, mem_src_o, ir_we_o, pc_we_o, reg_we_o;
  logic       alu_src_b_o, muldiv_start_o, trap_o;
  logic [1:0] pc_src_o, alu_op_o, alu_src_a_o, wb_sel_o, trap_cause_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct7_i(funct7_i),
    .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i),
    .muldiv_done_i(muldiv_done_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_src_o(mem_src_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
    .pc_src_o(pc_src_o), .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
    .muldiv_start_o(muldiv_start_o), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .state_o(state_o)
  );

  // Expected observable outputs for one clock cycle.
  typedef struct packed {
    logic [2:0] st;
    logic       req, we, src, irwe, pcwe;
    logic [1:0] pcs, aluop, srca;
    logic       srcb, regwe;
    logic [1:0] wbs;
    logic       trap, mds;
    logic [1:0] cause;
  } exp_t;

  typedef struct {
    exp_t e;
    logic rdy, tkn, dn, dec;
  } rec_t;

  rec_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  logic [1:0] model_cause = 2'b00;
  logic [6:0] cur_opc, cur_f7;

  function automatic exp_t mk(input logic [2:0] st);
    exp_t r = '0;
    r.st    = st;
    r.cause = model_cause;
    return r;
  endfunction

  task automatic push(input exp_t e, input logic rdy, input logic tkn, input logic dn, input logic dec);
    rec_t r;
    r.e = e; r.rdy = rdy; r.tkn = tkn; r.dn = dn; r.dec = dec;
    q.push_back(r);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push_trap();
    exp_t e = mk(3'd6);
    e.trap = 1'b1; e.pcwe = 1'b1; e.pcs = 2'b11;
    push(e, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic push_wb(input logic [1:0] wbs, input logic [1:0] pcs);
    exp_t e = mk(3'd4);
    e.regwe = 1'b1; e.pcwe = 1'b1; e.wbs = wbs; e.pcs = pcs;
    push(e, rb(), rb(), rb(), 1'b0);
  endtask

  // A memory access: w unanswered cycles, then the ready cycle, unless w
  // reaches the timeout, in which case the access ends in a timeout trap.
  task automatic wait_phase(input exp_t base, input exp_t fin, input int w, output bit ok);
    for (int i = 0; i < w && i < TMO; i++) push(base, 1'b0, rb(), rb(), 1'b0);
    if (w >= TMO) begin
      model_cause = 2'b10;
      push_trap();
      ok = 1'b0;
    end else begin
      push(fin, 1'b1, rb(), rb(), 1'b0);
      ok = 1'b1;
    end
  endtask

  // Reference model: the cycle-by-cycle story of one instruction.
  task automatic plan(input logic [6:0] opc, input logic [6:0] f7, input int fw,
                      input int mw, input logic tkn, input int dw);
    exp_t e, fin;
    bit   ok;
    bit   is_mul;
    cur_opc = opc;
    cur_f7  = f7;
    is_mul  = (opc == 7'b0110011) && (f7 == 7'b0000001);
    e = mk(3'd0); e.req = 1'b1;
    fin = e; fin.irwe = 1'b1;
    wait_phase(e, fin, fw, ok);
    if (!ok) return;
    push(mk(3'd1), rb(), rb(), rb(), 1'b1);
    if (!(opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111}) || (is_mul && !MD)) begin
      model_cause = 2'b01;
      push_trap();
      return;
    end
    e = mk(3'd2);
    case (opc)
      7'b0110011: begin
        if (is_mul) begin
          push(e, rb(), rb(), rb(), 1'b0);
          for (int i = 1; i <= dw; i++) begin
            exp_t m = mk(3'd5);
            m.mds = (i == 1);
            push(m, rb(), rb(), logic'(i == dw), 1'b0);
          end
          push_wb(2'b11, 2'b00);
        end else begin
          e.aluop = 2'b10;
          push(e, rb(), rb(), rb(), 1'b0);
          push_wb(2'b00, 2'b00);
        end
      end
      7'b0010011: begin
        e.aluop = 2'b11; e.srcb = 1'b1;
        push(e, rb(), rb(), rb(), 1'b0);
        push_wb(2'b00, 2'b00);
      end
      7'b0000011, 7'b0100011: begin
        e.srcb = 1'b1;
        push(e, rb(), rb(), rb(), 1'b0);
        e = mk(3'd3); e.req = 1'b1; e.src = 1'b1; e.we = (opc == 7'b0100011);
        fin = e;
        if (opc == 7'b0100011) fin.pcwe = 1'b1;
        wait_phase(e, fin, mw, ok);
        if (ok && opc == 7'b0000011) push_wb(2'b01, 2'b00);
      end
      7'b1100011: begin
        e.aluop = 2'b01; e.pcwe = 1'b1; e.pcs = tkn ? 2'b01 : 2'b00;
        push(e, rb(), tkn, rb(), 1'b0);
      end
      7'b1101111: begin
        push(e, rb(), rb(), rb(), 1'b0);
        push_wb(2'b10, 2'b01);
      end
      7'b1100111: begin
        push(e, rb(), rb(), rb(), 1'b0);
        push_wb(2'b10, 2'b10);
      end
      7'b0110111: begin
        e.srca = 2'b10; e.srcb = 1'b1;
        push(e, rb(), rb(), rb(), 1'b0);
        push_wb(2'b00, 2'b00);
      end
      default: begin
        e.srca = 2'b01; e.srcb = 1'b1;
        push(e, rb(), rb(), rb(), 1'b0);
        push_wb(2'b00, 2'b00);
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Plays queued cycles (at most limit, -1 = all). Entered and left at a
  // falling edge; opcode_i carries junk except in DECODE, proving the latch.
  task automatic run(input int limit, input string tag);
    int n = 0;
    while (q.size() > 0 && (limit < 0 || n < limit)) begin
      rec_t r = q.pop_front();
      exp_t obs;
      mem_ready_i    = r.rdy;
      branch_taken_i = r.tkn;
      muldiv_done_i  = r.dn;
      opcode_i       = r.dec ? cur_opc : 7'($urandom);
      funct7_i       = r.dec ? cur_f7  : 7'($urandom);
      #1;
      obs = {state_o, mem_req_o, mem_we_o, mem_src_o, ir_we_o, pc_we_o, pc_src_o,
             alu_op_o, alu_src_a_o, alu_src_b_o, reg_we_o, wb_sel_o, trap_o,
             muldiv_start_o, trap_cause_o};
      checks++;
      assert (obs === r.e) else begin
        fails++;
        $error("FAIL %s cycle %0d: got %h expected %h", tag, n, obs, r.e);
      end
      @(negedge clk);
      n++;
    end
    q.delete();
  endtask

  initial begin
    rst_ni = 1'b0; opcode_i = '0; funct7_i = '0;
    mem_ready_i = 1'b0; branch_taken_i = 1'b0; muldiv_done_i = 1'b0;
    repeat (2) @(negedge clk);
    mem_ready_i = 1'b1;
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_req", 32'(mem_req_o), 32'd0);
    chk("reset_cause", 32'(trap_cause_o), 32'd0);
    chk("reset_pcwe", 32'(pc_we_o), 32'd0);
    chk("reset_irwe", 32'(ir_we_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    plan(7'b0110011, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "add");
    plan(7'b0000011, 7'b0000000, 0, 3, 1'b0, 1); run(-1, "lw_wait3");
    plan(7'b1100011, 7'b0000000, 0, 0, 1'b1, 1); run(-1, "beq_taken");
    plan(7'b1100011, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "beq_not_taken");
    plan(7'b0110011, 7'b0000000, 16, 0, 1'b0, 1); run(-1, "fetch_timeout");
    plan(7'b0110011, 7'b0000000, 15, 0, 1'b0, 1); run(-1, "fetch_ready_at_16");
    plan(7'b1111111, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "illegal");
    plan(7'b0110011, 7'b0000001, 0, 0, 1'b0, 5); run(-1, "mul");
    plan(7'b0100011, 7'b0000000, 2, 1, 1'b0, 1); run(-1, "sw");
    plan(7'b1101111, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "jal");
    plan(7'b1100111, 7'b0000000, 1, 0, 1'b0, 1); run(-1, "jalr");
    plan(7'b0110111, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "lui");
    plan(7'b0010111, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "auipc");
    plan(7'b0010011, 7'b0000000, 0, 0, 1'b0, 1); run(-1, "addi");
    plan(7'b0100011, 7'b0000000, 0, 16, 1'b0, 1); run(-1, "sw_mem_timeout");

    // Asynchronous reset while a load is waiting in MEM.
    plan(7'b0000011, 7'b0000000, 0, 10, 1'b0, 1); run(5, "lw_before_reset");
    mem_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("midmem_reset_state", 32'(state_o), 32'd0);
    chk("midmem_reset_req", 32'(mem_req_o), 32'd0);
    chk("midmem_reset_cause", 32'(trap_cause_o), 32'd0);
    model_cause = 2'b00;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    for (int k = 0; k < 80; k++) begin
      logic [6:0] ops [9];
      logic [6:0] opc, f7;
      int         sel, fw, mw;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      sel = $urandom_range(0, 10);
      f7  = 7'($urandom);
      if (sel < 9) opc = ops[sel];
      else if (sel == 9) opc = 7'($urandom);
      else begin opc = 7'b0110011; f7 = 7'b0000001; end
      fw = $urandom_range(0, 19);
      fw = (fw < 12) ? $urandom_range(0, 2) : (fw < 19) ? $urandom_range(3, 15) : TMO;
      mw = $urandom_range(0, 19);
      mw = (mw < 12) ? $urandom_range(0, 2) : (mw < 19) ? $urandom_range(3, 15) : TMO;
      plan(opc, f7, fw, mw, rb(), $urandom_range(1, 6));
      run(-1, "random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
